// File: rtl/led_mode_controller_if.sv
// Board-side signal bundle for the LED sequencer: tact buttons in, LED drive and status out.
// Latency: none, plain wires.
// Backpressure: none; every signal is a free-running level.
interface led_mode_controller_if;
    logic       Tact1;
    logic       Tact2;
    logic [7:0] USER_LED;
    logic [1:0] MODE;
    logic       PAUSED;

    modport master (output Tact1, Tact2, input  USER_LED, MODE, PAUSED);
    modport slave  (input  Tact1, Tact2, output USER_LED, MODE, PAUSED);
endinterface

// File: rtl/led_mode_controller.sv
// LED bank sequencer: button sync/debounce (LED_DEBOUNCE_EN), four display modes, prescaled stepping.
// Latency: button to MODE/PAUSED 4 + 2^W_DB clocks (4 without LED_DEBOUNCE_EN); USER_LED one clock later.
// Backpressure: none; buttons are sampled every clock and outputs update every clock.
module led_mode_controller #(
    parameter int W_CNT = 23,
    parameter int W_DB  = 18
) (
    input  logic                 CLK_24MHz,
    input  logic                 RST_n,
    led_mode_controller_if.slave io
);
    typedef enum logic [1:0] {
        CHASE_UP = 2'd0,
        CHASE_DN = 2'd1,
        BOUNCE   = 2'd2,
        BLINK    = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    if (W_DB < 1 || W_CNT < 1) begin : g_width_check
        $error("W_DB and W_CNT must be at least 1");
    end

    // Bit 0 carries Tact1, bit 1 carries Tact2 through the whole input path.
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] level;
    logic [1:0] level_d;
    logic [1:0] press;

    always_ff @(posedge CLK_24MHz or negedge RST_n) begin
        if (!RST_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {io.Tact2, io.Tact1};
            sync2 <= sync1;
        end
    end

`ifdef LED_DEBOUNCE_EN
    logic [1:0][W_DB-1:0] db_cnt;

    // A new level is taken only after 2^W_DB consecutive samples disagree with the accepted one.
    always_ff @(posedge CLK_24MHz or negedge RST_n) begin
        if (!RST_n) begin
            level  <= 2'b11;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (&db_cnt[i]) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign level = sync2;
`endif

    always_ff @(posedge CLK_24MHz or negedge RST_n) begin
        if (!RST_n) begin
            level_d <= 2'b11;
            press   <= 2'b00;
        end else begin
            level_d <= level;
            press   <= level_d & ~level;
        end
    end

    logic mode_adv;
    logic pause_tgl;
    assign mode_adv  = press[0];
    assign pause_tgl = press[1];

    mode_e            mode_q,   mode_n;
    dir_e             dir_q,    dir_n;
    logic             paused_q, paused_n;
    logic             phase_q,  phase_n;
    logic [2:0]       pos_q,    pos_n;
    logic [W_CNT-1:0] presc_q,  presc_n;
    logic [7:0]       led_q,    led_n;
    logic             tick;

    always_ff @(posedge CLK_24MHz or negedge RST_n) begin
        if (!RST_n) begin
            mode_q   <= CHASE_UP;
            dir_q    <= DIR_UP;
            paused_q <= 1'b0;
            phase_q  <= 1'b0;
            pos_q    <= '0;
            presc_q  <= '1;
            led_q    <= 8'hFF;
        end else begin
            mode_q   <= mode_n;
            dir_q    <= dir_n;
            paused_q <= paused_n;
            phase_q  <= phase_n;
            pos_q    <= pos_n;
            presc_q  <= presc_n;
            led_q    <= led_n;
        end
    end

    always_comb begin
        mode_n   = mode_q;
        dir_n    = dir_q;
        paused_n = paused_q;
        phase_n  = phase_q;
        pos_n    = pos_q;
        presc_n  = presc_q;
        led_n    = 8'hFF;
        tick     = !paused_q && (presc_q == '0);

        // Decrementing through zero lands on all-ones, which is the reload value.
        if (!paused_q) begin
            presc_n = presc_q - 1'b1;
        end

        if (mode_adv) begin
            mode_n  = mode_e'(mode_q + 2'd1);
            dir_n   = DIR_UP;
            phase_n = 1'b0;
            pos_n   = '0;
            presc_n = '1;
        end else if (tick) begin
            case (mode_q)
                CHASE_UP: pos_n = pos_q + 3'd1;
                CHASE_DN: pos_n = pos_q - 3'd1;
                BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        if (pos_q == 3'd7) begin
                            dir_n = DIR_DN;
                            pos_n = 3'd6;
                        end else begin
                            pos_n = pos_q + 3'd1;
                        end
                    end else begin
                        if (pos_q == 3'd0) begin
                            dir_n = DIR_UP;
                            pos_n = 3'd1;
                        end else begin
                            pos_n = pos_q - 3'd1;
                        end
                    end
                end
                default: phase_n = ~phase_q;
            endcase
        end

        if (pause_tgl) begin
            paused_n = ~paused_q;
        end

        // LEDs are active-low: a lit LED is a 0 bit.
        if (mode_q == BLINK) begin
            led_n = phase_q ? 8'h00 : 8'hFF;
        end else begin
            led_n = ~(8'h01 << pos_q);
        end
    end

    assign io.USER_LED = led_q;
    assign io.MODE     = mode_q;
    assign io.PAUSED   = paused_q;
endmodule

// File: tb/tb_led_mode_controller.sv
// Bench for led_mode_controller: directed steps plus random button activity against a step-count model.
// Works with or without LED_DEBOUNCE_EN; the model picks the matching press-detection rule.
module tb_led_mode_controller;
    localparam int W_CNT  = 4;
    localparam int W_DB   = 3;
    localparam int PERIOD = 1 << W_CNT;
    localparam int DB_LEN = 1 << W_DB;
    localparam int MAXT   = 16384;
`ifdef LED_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    logic CLK_24MHz = 1'b0;
    logic RST_n     = 1'b1;

    led_mode_controller_if bus ();

    led_mode_controller #(.W_CNT(W_CNT), .W_DB(W_DB)) dut (
        .CLK_24MHz (CLK_24MHz),
        .RST_n     (RST_n),
        .io        (bus)
    );

    always #5 CLK_24MHz = ~CLK_24MHz;

    // Reference model: mode, pause flag, steps taken since the last mode change,
    // and running clocks since the last prescaler reload.
    int         total = 0;
    int         bad   = 0;
    int         t;
    int         m_mode;
    bit         m_paused;
    int         m_k;
    int         m_r;
    logic [7:0] m_led;
    bit         drv1;
    bit         drv2;
    bit         raw [2][MAXT];
    bit         lv  [2][MAXT];
    string      phase_tag;

    function automatic bit s2_at(input int b, input int tt);
        return (tt == 0) ? 1'b1 : raw[b][tt-1];
    endfunction

    function automatic logic [7:0] pattern_of(input int mode, input int k);
        int pos;
        int m;
        case (mode)
            0: pos = k % 8;
            1: pos = (8 - (k % 8)) % 8;
            2: begin
                m   = k % 14;
                pos = (m <= 7) ? m : 14 - m;
            end
            default: return ((k % 2) == 1) ? 8'h00 : 8'hFF;
        endcase
        return ~(8'h01 << pos);
    endfunction

    task automatic model_reset();
        t        = 0;
        raw[0][0] = 1'b1;
        raw[1][0] = 1'b1;
        lv[0][0]  = 1'b1;
        lv[1][0]  = 1'b1;
        m_mode   = 0;
        m_paused = 1'b0;
        m_k      = 0;
        m_r      = 0;
        m_led    = 8'hFF;
    endtask

    task automatic model_edge();
        bit [1:0]   press;
        bit         tick;
        bit         v;
        bit         all_v;
        logic [7:0] led_next;
        t++;
        if (t >= MAXT) begin
            $display("FAIL model_history overflow t=%0d limit=%0d", t, MAXT);
            $fatal(1);
        end
        raw[0][t] = drv1;
        raw[1][t] = drv2;
        for (int b = 0; b < 2; b++) begin
            if (!DB_ON) begin
                lv[b][t] = s2_at(b, t);
            end else begin
                v     = s2_at(b, t - 1);
                all_v = (t >= DB_LEN) && (v != lv[b][t-1]);
                for (int j = t - DB_LEN; j < t; j++)
                    if (j >= 0 && s2_at(b, j) != v) all_v = 1'b0;
                lv[b][t] = all_v ? v : lv[b][t-1];
            end
            press[b] = (t >= 3) && lv[b][t-3] && !lv[b][t-2];
        end
        led_next = pattern_of(m_mode, m_k);
        tick     = !m_paused && (m_r == PERIOD - 1);
        if (press[0]) begin
            m_mode = (m_mode + 1) % 4;
            m_k    = 0;
            m_r    = 0;
        end else if (tick) begin
            m_k++;
            m_r = 0;
        end else if (!m_paused) begin
            m_r++;
        end
        if (press[1]) m_paused = !m_paused;
        m_led = led_next;
    endtask

    task automatic check_all();
        total++;
        assert (bus.USER_LED === m_led) else begin
            bad++;
            $error("FAIL %s USER_LED t=%0d got=%h exp=%h", phase_tag, t, bus.USER_LED, m_led);
        end
        total++;
        assert (bus.MODE === 2'(m_mode)) else begin
            bad++;
            $error("FAIL %s MODE t=%0d got=%0d exp=%0d", phase_tag, t, bus.MODE, m_mode);
        end
        total++;
        assert (bus.PAUSED === m_paused) else begin
            bad++;
            $error("FAIL %s PAUSED t=%0d got=%b exp=%b", phase_tag, t, bus.PAUSED, m_paused);
        end
    endtask

    // Starts and ends on a falling clock edge.
    task automatic cycle(input bit a, input bit b);
        drv1      = a;
        drv2      = b;
        bus.Tact1 = a;
        bus.Tact2 = b;
        @(posedge CLK_24MHz);
        model_edge();
        #1;
        check_all();
        @(negedge CLK_24MHz);
    endtask

    initial begin
        int lat;
        int guard;
        int len;
        bit a;
        bit b;
        lat = DB_ON ? 3 + DB_LEN : 3;

        bus.Tact1 = 1'b1;
        bus.Tact2 = 1'b1;
        drv1 = 1'b1;
        drv2 = 1'b1;
        model_reset();
        phase_tag = "reset";
        #2 RST_n = 1'b0;
        #1 check_all();
        @(negedge CLK_24MHz);
        @(negedge CLK_24MHz);
        check_all();
        RST_n = 1'b1;

        phase_tag = "chase_up";
        repeat (8 * PERIOD + 4) cycle(1'b1, 1'b1);

        phase_tag = "glitch";
        repeat (5) cycle(1'b0, 1'b1);
        repeat (20) cycle(1'b1, 1'b1);
        phase_tag = "hold_t1";
        repeat (20) cycle(1'b0, 1'b1);
        repeat (3 * PERIOD) cycle(1'b1, 1'b1);

        phase_tag = "to_bounce";
        guard = 0;
        while (m_mode != 2 && guard < 6) begin
            repeat (12) cycle(1'b0, 1'b1);
            repeat (20) cycle(1'b1, 1'b1);
            guard++;
        end
        phase_tag = "bounce";
        repeat (16 * PERIOD + 10) cycle(1'b1, 1'b1);

        phase_tag = "pause";
        repeat (5) cycle(1'b1, 1'b1);
        repeat (12) cycle(1'b1, 1'b0);
        repeat (100) cycle(1'b1, 1'b1);
        phase_tag = "resume";
        repeat (12) cycle(1'b1, 1'b0);
        repeat (2 * PERIOD) cycle(1'b1, 1'b1);

        // Line both presses up so they land on the same edge as a prescaler tick.
        phase_tag = "coincide";
        guard = 0;
        while ((m_paused || ((m_r + lat) % PERIOD) != PERIOD - 1) && guard < 4 * PERIOD) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        repeat (12) cycle(1'b0, 1'b0);
        repeat (2 * PERIOD) cycle(1'b1, 1'b1);

        phase_tag = "blink";
        guard = 0;
        while (m_mode != 3 && guard < 6) begin
            repeat (12) cycle(1'b0, 1'b1);
            repeat (20) cycle(1'b1, 1'b1);
            guard++;
        end
        repeat (4 * PERIOD) cycle(1'b1, 1'b1);

        phase_tag = "random_a";
        for (int s = 0; s < 150; s++) begin
            len = $urandom_range(1, 24);
            a   = ($urandom_range(0, 2) != 0);
            b   = ($urandom_range(0, 3) != 0);
            repeat (len) cycle(a, b);
        end

        // Asynchronous reset with Tact2 held down across the release.
        phase_tag = "mid_reset";
        RST_n = 1'b0;
        bus.Tact2 = 1'b0;
        drv2 = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge CLK_24MHz);
        @(negedge CLK_24MHz);
        check_all();
        RST_n = 1'b1;
        repeat (20) cycle(1'b1, 1'b0);

        phase_tag = "random_b";
        for (int s = 0; s < 80; s++) begin
            len = $urandom_range(1, 30);
            a   = ($urandom_range(0, 3) != 0);
            b   = ($urandom_range(0, 2) != 0);
            repeat (len) cycle(a, b);
        end
        repeat (2 * PERIOD) cycle(1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
